// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU: R-type function codes, FSM state
// encoding and the kind of multi-cycle operation held by the iterative datapath.
package seq_alu_pkg;

  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_DIVU  = 6'd27;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_SLT   = 6'd42;

  typedef enum logic {StIdle, StIter} state_e;

  typedef enum logic {OpDiv, OpMul} op_kind_e;

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative datapath: restoring unsigned divide (and, with SEQ_TOTAL_ALU_MULTU_EN
// defined, shift-add unsigned multiply), one step per cycle over WIDTH cycles.
// Ports:
//   clk_i, rst_ni  - clock, synchronous active-low reset
//   start_i        - load operands and counter (WIDTH-1)
//   kind_i         - DIV or MUL (only with SEQ_TOTAL_ALU_MULTU_EN)
//   a_i, b_i       - operand A / operand B at start
//   step_i         - perform one step this cycle
//   last_o         - counter is zero: the current step is the final one
//   hi_o, lo_o     - result of the current step (remainder:quotient or product)
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
`ifdef SEQ_TOTAL_ALU_MULTU_EN
  input  op_kind_e         kind_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             step_i,
  output logic             last_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned SHW = $clog2(WIDTH);

  // rem: remainder (DIV) / upper product (MUL); quo: quotient / lower product
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, opd_q, opd_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]   trial, diff;
`ifdef SEQ_TOTAL_ALU_MULTU_EN
  op_kind_e         kind_q, kind_d;
  logic [WIDTH:0]   sum;
`endif

  assign last_o = (cnt_q == '0);

  // One step of the selected algorithm.
  always_comb begin
    trial = {rem_q, quo_q[WIDTH-1]};
    diff  = trial - {1'b0, opd_q};
    // rem < divisor always holds, so diff's MSB is set exactly when trial < divisor.
    if (!diff[WIDTH]) begin
      hi_o = diff[WIDTH-1:0];
      lo_o = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_o = trial[WIDTH-1:0];
      lo_o = {quo_q[WIDTH-2:0], 1'b0};
    end
`ifdef SEQ_TOTAL_ALU_MULTU_EN
    sum = {1'b0, rem_q} + ({1'b0, opd_q} & {(WIDTH + 1){quo_q[0]}});
    if (kind_q == OpMul) begin
      hi_o = sum[WIDTH:1];
      lo_o = {sum[0], quo_q[WIDTH-1:1]};
    end
`endif
  end

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    opd_d = opd_q;
    cnt_d = cnt_q;
`ifdef SEQ_TOTAL_ALU_MULTU_EN
    kind_d = kind_q;
`endif
    if (start_i) begin
      rem_d = '0;
      quo_d = a_i;
      opd_d = b_i;
      cnt_d = SHW'(WIDTH - 1);
`ifdef SEQ_TOTAL_ALU_MULTU_EN
      kind_d = kind_i;
      if (kind_i == OpMul) begin
        // Multiplier sits in the low half and is consumed LSB first.
        quo_d = b_i;
        opd_d = a_i;
      end
`endif
    end else if (step_i) begin
      rem_d = hi_o;
      quo_d = lo_o;
      if (!last_o) cnt_d = cnt_q - SHW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rem_q <= '0;
      quo_q <= '0;
      opd_q <= '0;
      cnt_q <= '0;
`ifdef SEQ_TOTAL_ALU_MULTU_EN
      kind_q <= OpDiv;
`endif
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      opd_q <= opd_d;
      cnt_q <= cnt_d;
`ifdef SEQ_TOTAL_ALU_MULTU_EN
      kind_q <= kind_d;
`endif
    end
  end

endmodule

// File: rtl/seq_total_alu.sv
// Handshaked MIPS-style R-type ALU. Single-cycle ops complete at acceptance;
// DIVU (and MULTU when SEQ_TOTAL_ALU_MULTU_EN is defined) iterate for WIDTH
// cycles in seq_alu_iter with ready low. HI/LO are held here.
// Ports:
//   clk, reset (sync, active-low)
//   valid/ready     - request handshake, accepted on valid && ready
//   dataA, dataB    - operands; shift amount is dataB[SHW-1:0]
//   Signal          - 6-bit function code
//   Output          - registered result, done pulses when it updates
//   div_zero        - sticky divide-by-zero flag, cleared by next accepted DIVU
module seq_total_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  output logic             ready,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output,
  output logic             done,
  output logic             div_zero
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, out_q, out_d;
  logic             done_q, done_d, dz_q, dz_d;
  logic             accept, start, start_div, start_mul, step, iter_last;
  logic [WIDTH-1:0] iter_hi, iter_lo;

  assign accept    = valid && ready;
  assign start_div = accept && (Signal == FN_DIVU) && (dataB != '0);
`ifdef SEQ_TOTAL_ALU_MULTU_EN
  assign start_mul = accept && (Signal == FN_MULTU);
`else
  assign start_mul = 1'b0;
`endif
  assign start     = start_div || start_mul;
  assign step      = (state_q == StIter);

  seq_alu_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk_i   (clk),
    .rst_ni  (reset),
    .start_i (start),
`ifdef SEQ_TOTAL_ALU_MULTU_EN
    .kind_i  (start_mul ? OpMul : OpDiv),
`endif
    .a_i     (dataA),
    .b_i     (dataB),
    .step_i  (step),
    .last_o  (iter_last),
    .hi_o    (iter_hi),
    .lo_o    (iter_lo)
  );

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (start) state_d = StIter;
      StIter: if (iter_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state_q == StIdle);
  end

  // Result, HI/LO and flag updates.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    out_d  = out_q;
    done_d = 1'b0;
    dz_d   = dz_q;
    if (accept) begin
      done_d = 1'b1;
      case (Signal)
        FN_AND:  out_d = dataA & dataB;
        FN_OR:   out_d = dataA | dataB;
        FN_ADD:  out_d = dataA + dataB;
        FN_SUB:  out_d = dataA - dataB;
        FN_SLT:  out_d = WIDTH'($signed(dataA) < $signed(dataB));
        FN_SRL:  out_d = dataA >> dataB[SHW-1:0];
        FN_MFHI: out_d = hi_q;
        FN_MFLO: out_d = lo_q;
        FN_DIVU: begin
          dz_d = (dataB == '0);
          if (dataB == '0) begin
            lo_d  = '1;
            hi_d  = dataA;
            out_d = '1;
          end else begin
            done_d = 1'b0;
          end
        end
`ifdef SEQ_TOTAL_ALU_MULTU_EN
        FN_MULTU: done_d = 1'b0;
`endif
        default: out_d = '0;
      endcase
    end else if (step && iter_last) begin
      // LO is the quotient for DIVU and the low product half for MULTU.
      hi_d   = iter_hi;
      lo_d   = iter_lo;
      out_d  = iter_lo;
      done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      out_q  <= out_d;
      done_q <= done_d;
      dz_q   <= dz_d;
    end
  end

  assign Output   = out_q;
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule
